// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the muldiv_seq sequencer
package muldiv_pkg;

  localparam int RV_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring divide iteration
// DIV mode: acc_in is {remainder, dividend/quotient}; the quotient bit is returned separately.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int RV = RV_DEFAULT
) (
  input  logic            op,
  input  logic [2*RV-1:0] acc_in,
  input  logic [2*RV-1:0] opnd,
  input  logic            bit_in,
  output logic [2*RV-1:0] acc_out,
  output logic            q_bit
);

  logic [RV:0]   trial;
  logic          fits;
  logic [RV-1:0] diff;

  always_comb begin
    trial   = acc_in[2*RV-1:RV-1];
    fits    = (trial >= {1'b0, opnd[RV-1:0]});
    // Only consumed when fits, so the difference always fits in RV bits.
    diff    = trial[RV-1:0] - opnd[RV-1:0];
    acc_out = acc_in;
    q_bit   = 1'b0;
    if (op == OP_MUL) begin
      if (bit_in) begin
        acc_out = acc_in + opnd;
      end
    end else if (fits) begin
      acc_out = {diff, acc_in[RV-2:0], 1'b0};
      q_bit   = 1'b1;
    end else begin
      acc_out = {acc_in[2*RV-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative unsigned multiply/divide sequencer for the vc32 execute stage
// Optional MULDIV_EARLY_EN: multiply finishes once the remaining multiplier bits are zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int RV = RV_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mult,
  input  logic          div,
  input  logic [RV-1:0] a,
  input  logic [RV-1:0] b,
  input  logic [3:0]    rd_in,
  input  logic          kill,
  output logic          busy,
  output logic          done,
  output logic [RV-1:0] result,
  output logic [RV-1:0] hi,
  output logic [3:0]    rd_out
);

  localparam int CW = $clog2(RV) + 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*RV-1:0] acc;
  logic [2*RV-1:0] mcand;
  logic [RV-1:0]   mplier;
  logic [3:0]      rd_q;

  logic [2*RV-1:0] step_acc;
  logic            step_q;
  logic [2*RV-1:0] acc_nx;
  logic [CW-1:0]   cnt_nx;
  logic [RV-1:0]   mplier_nx;
  logic            fin;
  logic            step_op;

  assign step_op = (state == DIV) ? OP_DIV : OP_MUL;

  muldiv_step #(.RV(RV)) u_step (
    .op      (step_op),
    .acc_in  (acc),
    .opnd    (mcand),
    .bit_in  (mplier[0]),
    .acc_out (step_acc),
    .q_bit   (step_q)
  );

  always_comb begin
    acc_nx    = (state == DIV) ? {step_acc[2*RV-1:1], step_q} : step_acc;
    cnt_nx    = cnt - CW'(1);
    mplier_nx = mplier >> 1;
`ifdef MULDIV_EARLY_EN
    fin = (cnt_nx == '0) || ((state == MUL) && (mplier_nx == '0));
`else
    fin = (cnt_nx == '0);
`endif
  end

  assign busy = (state == MUL) || (state == DIV);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rd_q   <= '0;
      done   <= 1'b0;
      result <= '0;
      hi     <= '0;
      rd_out <= '0;
    end else if (kill) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          if (start && (mult ^ div)) begin
            cnt    <= CW'(RV);
            rd_q   <= rd_in;
            mplier <= b;
            if (mult) begin
              acc   <= '0;
              mcand <= {{RV{1'b0}}, a};
              state <= MUL;
`ifdef MULDIV_EARLY_EN
              if (b == '0) begin
                state  <= DONE;
                done   <= 1'b1;
                result <= '0;
                hi     <= '0;
                rd_out <= rd_in;
              end
`endif
            end else begin
              acc   <= {{RV{1'b0}}, a};
              mcand <= {{RV{1'b0}}, b};
              state <= DIV;
            end
          end
        end
        MUL, DIV: begin
          cnt <= cnt_nx;
          acc <= acc_nx;
          if (state == MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier_nx;
          end
          if (fin) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= acc_nx[RV-1:0];
            hi     <= acc_nx[2*RV-1:RV];
            rd_out <= rd_q;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq with an arithmetic reference model
module tb_muldiv_seq;

  localparam int RV = 32;
`ifdef MULDIV_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, mult, div, kill;
  logic [RV-1:0] a, b;
  logic [3:0]    rd_in;
  logic          busy, done;
  logic [RV-1:0] result, hi;
  logic [3:0]    rd_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  muldiv_seq #(.RV(RV)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mult   (mult),
    .div    (div),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result),
    .hi     (hi),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: cycles-remaining counter plus plain arithmetic results.
  logic          m_busy = 1'b0, m_done = 1'b0;
  logic [RV-1:0] m_res = '0, m_hi = '0, p_res = '0, p_hi = '0;
  logic [3:0]    m_rd = '0, p_rd = '0;
  logic [63:0]   prod;
  int            m_left = 0;

  function automatic int iters(input logic is_mul, input logic [RV-1:0] bv);
    int n = RV;
    if (EARLY && is_mul) begin
      n = 0;
      for (int i = 0; i < RV; i++) if (bv[i]) n = i + 1;
    end
    return n;
  endfunction

  function automatic int lat(input int early_lat, input int full_lat);
    return EARLY ? early_lat : full_lat;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_hi = '0; m_rd = '0; m_left = 0;
    end else if (kill) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_res = p_res; m_hi = p_hi; m_rd = p_rd;
      end
    end else begin
      m_done = 1'b0;
      if (start && (mult != div)) begin
        if (mult) begin
          prod  = {32'b0, a} * {32'b0, b};
          p_res = prod[31:0];
          p_hi  = prod[63:32];
        end else if (b == '0) begin
          p_res = '1;
          p_hi  = a;
        end else begin
          p_res = a / b;
          p_hi  = a % b;
        end
        p_rd   = rd_in;
        m_left = iters(mult, b);
        if (m_left == 0) begin
          m_done = 1'b1; m_res = p_res; m_hi = p_hi; m_rd = p_rd;
        end else begin
          m_busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'b0, busy}, {63'b0, m_busy});
      chk("done", {63'b0, done}, {63'b0, m_done});
      chk("result", {32'b0, result}, {32'b0, m_res});
      chk("hi", {32'b0, hi}, {32'b0, m_hi});
      chk("rd_out", {60'b0, rd_out}, {60'b0, m_rd});
    end
  end

  task automatic issue(input logic m, input logic d, input logic [RV-1:0] av,
                       input logic [RV-1:0] bv, input logic [3:0] rv);
    start = 1'b1; mult = m; div = d; a = av; b = bv; rd_in = rv;
    @(negedge clk);
    start = 1'b0; mult = 1'b0; div = 1'b0;
  endtask

  // Called at the negedge of cycle T+1; latency is counted so that done in cycle T+n gives n.
  task automatic run(input string name, input int exp_lat, input logic [RV-1:0] er,
                     input logic [RV-1:0] eh, input logic [3:0] erd);
    int c = 1;
    while (done !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_lat"}, 64'(c), 64'(exp_lat));
    chk({name, "_res"}, {32'b0, result}, {32'b0, er});
    chk({name, "_hi"}, {32'b0, hi}, {32'b0, eh});
    chk({name, "_rd"}, {60'b0, rd_out}, {60'b0, erd});
  endtask

  task automatic no_done(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mult = 1'b0; div = 1'b0; kill = 1'b0;
    a = '0; b = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_result", {32'b0, result}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_rd", {60'b0, rd_out}, 64'd0);
    chk_en = 1'b1;
    reset  = 1'b1;
    @(negedge clk);

    issue(1'b1, 1'b0, 32'd7, 32'd6, 4'd3);
    chk("t1_busy_first", {63'b0, busy}, 64'd1);
    run("t1", lat(4, 33), 32'd42, 32'd0, 4'd3);
    chk("t1_model_pin", {32'b0, m_res}, 64'd42);

    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5);
    run("t2a", 33, 32'h0000_0001, 32'hFFFF_FFFE, 4'd5);
    issue(1'b0, 1'b1, 32'd100, 32'd7, 4'd6);
    run("t2b", 33, 32'd14, 32'd2, 4'd6);
    chk("t2b_model_pin", {32'b0, m_hi}, 64'd2);

    issue(1'b0, 1'b1, 32'h1234, 32'd0, 4'd7);
    run("t3", 33, 32'hFFFF_FFFF, 32'h1234, 4'd7);
    @(negedge clk);

    issue(1'b0, 1'b1, 32'd1000, 32'd3, 4'd8);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("t4_kill_busy", {63'b0, busy}, 64'd0);
    chk("t4_kill_res", {32'b0, result}, 64'hFFFF_FFFF);
    chk("t4_kill_hi", {32'b0, hi}, 64'h1234);
    no_done("t4_kill_nodone", 40);

    start = 1'b1; mult = 1'b1; kill = 1'b1; a = 32'd2; b = 32'd2; rd_in = 4'd9;
    @(negedge clk);
    start = 1'b0; mult = 1'b0; kill = 1'b0;
    chk("t4_startkill_busy", {63'b0, busy}, 64'd0);
    no_done("t4_startkill_nodone", 36);

    issue(1'b1, 1'b1, 32'd3, 32'd3, 4'd10);
    chk("t4_both_busy", {63'b0, busy}, 64'd0);
    issue(1'b0, 1'b0, 32'd3, 32'd3, 4'd10);
    chk("t4_none_busy", {63'b0, busy}, 64'd0);
    no_done("t4_illegal_nodone", 36);

    issue(1'b1, 1'b0, 32'd9, 32'd9, 4'd11);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", {63'b0, busy}, 64'd0);
    chk("t5_rst_done", {63'b0, done}, 64'd0);
    chk("t5_rst_res", {32'b0, result}, 64'd0);
    chk("t5_rst_hi", {32'b0, hi}, 64'd0);
    chk("t5_rst_rd", {60'b0, rd_out}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 32'd12, 32'd11, 4'd2);
    run("t5", lat(5, 33), 32'd132, 32'd0, 4'd2);
    @(negedge clk);

    if (EARLY) begin
      issue(1'b1, 1'b0, 32'd5, 32'd3, 4'd1);
      run("e1", 3, 32'd15, 32'd0, 4'd1);
      @(negedge clk);
      issue(1'b1, 1'b0, 32'hABCD, 32'd0, 4'd2);
      run("e2", 1, 32'd0, 32'd0, 4'd2);
      @(negedge clk);
      issue(1'b1, 1'b0, 32'd1, 32'h8000_0000, 4'd3);
      run("e3", 33, 32'h8000_0000, 32'd0, 4'd3);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
